// File: rtl/board_update_ctrl.sv
// Board-state owner for the 8x8 checkers display: validates move/init requests
// and commits board writes only during vertical blanking so frames never tear.
module board_update_ctrl #(
  parameter int CNT_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_blank,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_init,
  input  logic [2:0]             req_src_row,
  input  logic [2:0]             req_src_col,
  input  logic [2:0]             req_dst_row,
  input  logic [2:0]             req_dst_col,
  input  logic                   req_promote,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_ok,
  output logic [1:0]             rsp_err,
  output logic [7:0][7:0][2:0]   board_pos,
  output logic [CNT_W-1:0]       move_count,
  output logic [2:0]             dbg_state
);

  // Handshakes: a transfer happens on any clk edge where valid & ready are both
  // high; the producer holds its payload until then, and the consumer side
  // (rsp_*) holds rsp_ok/rsp_err stable while rsp_valid is high and rsp_ready low.

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    WAIT_BLANK = 3'd2,
    WRITE      = 3'd3,
    RESP       = 3'd4
  } state_t;

  state_t state, state_next;

  logic       cap_init;
  logic [2:0] cap_src_row, cap_src_col, cap_dst_row, cap_dst_col;
  logic       cap_promote;
  logic [2:0] src_cell, dst_cell;
  logic [1:0] chk_err;

  // Dark squares ((row+col) odd) carry black men on rows 0-2, white on rows 5-7.
  function automatic logic [7:0][7:0][2:0] start_layout();
    logic [7:0][7:0][2:0] b;
    b = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (((r + c) % 2) == 1) begin
          if (r <= 2)      b[r][c] = 3'b011;
          else if (r >= 5) b[r][c] = 3'b001;
        end
      end
    end
    return b;
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  assign src_cell = board_pos[cap_src_row][cap_src_col];
  assign dst_cell = board_pos[cap_dst_row][cap_dst_col];

  // Error priority: identical squares, then empty source, then occupied destination.
  always_comb begin
    chk_err = 2'b00;
    if ({cap_src_row, cap_src_col} == {cap_dst_row, cap_dst_col}) chk_err = 2'b11;
    else if (!src_cell[0])                                           chk_err = 2'b01;
    else if (dst_cell[0])                                            chk_err = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (req_valid) state_next = CHECK;
      CHECK:      state_next = (cap_init || chk_err == 2'b00) ? WAIT_BLANK : RESP;
      WAIT_BLANK: if (frame_blank) state_next = WRITE;
      WRITE:      state_next = RESP;
      RESP:       if (rsp_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_pos   <= start_layout();
      move_count  <= '0;
      rsp_ok      <= 1'b0;
      rsp_err     <= 2'b00;
      cap_init    <= 1'b0;
      cap_src_row <= '0;
      cap_src_col <= '0;
      cap_dst_row <= '0;
      cap_dst_col <= '0;
      cap_promote <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        cap_init    <= req_init;
        cap_src_row <= req_src_row;
        cap_src_col <= req_src_col;
        cap_dst_row <= req_dst_row;
        cap_dst_col <= req_dst_col;
        cap_promote <= req_promote;
      end
      if (state == CHECK && !cap_init && chk_err != 2'b00) begin
        rsp_ok  <= 1'b0;
        rsp_err <= chk_err;
      end
      if (state == WRITE) begin
        rsp_ok  <= 1'b1;
        rsp_err <= 2'b00;
        if (cap_init) begin
          board_pos  <= start_layout();
          move_count <= '0;
        end else begin
          board_pos[cap_dst_row][cap_dst_col] <= {src_cell[2] | cap_promote, src_cell[1], 1'b1};
          board_pos[cap_src_row][cap_src_col] <= 3'b000;
          move_count <= move_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_board_update_ctrl.sv
// Directed bench for board_update_ctrl: start layout, moves, blanking wait,
// error codes, promotion with response back-pressure, init and mid-flight reset.
module tb_board_update_ctrl;

  localparam int CNT_W = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 frame_blank;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_init;
  logic [2:0]           req_src_row, req_src_col, req_dst_row, req_dst_col;
  logic                 req_promote;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_ok;
  logic [1:0]           rsp_err;
  logic [7:0][7:0][2:0] board_pos;
  logic [CNT_W-1:0]     move_count;
  logic [2:0]           dbg_state;

  logic [7:0][7:0][2:0] start_b, exp_board;
  int n_vec = 0;
  int n_err = 0;

  board_update_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .frame_blank(frame_blank),
    .req_valid(req_valid), .req_ready(req_ready), .req_init(req_init),
    .req_src_row(req_src_row), .req_src_col(req_src_col),
    .req_dst_row(req_dst_row), .req_dst_col(req_dst_col),
    .req_promote(req_promote), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ok(rsp_ok), .rsp_err(rsp_err), .board_pos(board_pos),
    .move_count(move_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1 (CHECK).
  task automatic send(input logic init, input logic [2:0] sr, input logic [2:0] sc,
                      input logic [2:0] dr, input logic [2:0] dc, input logic prom);
    chk("req_ready_before_send", req_ready, 1);
    req_valid = 1'b1; req_init = init; req_promote = prom;
    req_src_row = sr; req_src_col = sc; req_dst_row = dr; req_dst_col = dc;
    @(negedge clk);
    // Scramble the payload to prove the captured copy is what gets used.
    req_valid = 1'b0; req_init = ~init; req_promote = ~prom;
    req_src_row = ~sr; req_src_col = ~sc; req_dst_row = ~dr; req_dst_col = ~dc;
  endtask

  task automatic finish_resp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_ack", rsp_valid, 0);
    chk("req_ready_after_ack", req_ready, 1);
  endtask

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        start_b[r][c] = (((r + c) % 2) == 1) ? ((r <= 2) ? 3'b011 : (r >= 5) ? 3'b001 : 3'b000) : 3'b000;
    exp_board = start_b;

    reset = 1'b1; frame_blank = 1'b1; req_valid = 1'b0; req_init = 1'b0;
    req_src_row = '0; req_src_col = '0; req_dst_row = '0; req_dst_col = '0;
    req_promote = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_b01", board_pos[0][1], 3'b011);
    chk("rst_b00", board_pos[0][0], 3'b000);
    chk("rst_b50", board_pos[5][0], 3'b001);
    chk("rst_b76", board_pos[7][6], 3'b001);
    chk("rst_row3", board_pos[3], 24'h0);
    chk("rst_board", board_pos, start_b);
    chk("rst_count", move_count, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_ok", rsp_ok, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_state", dbg_state, 0);

    // Move (5,0)->(4,1) with blanking already high: response at cycle 4
    send(1'b0, 3'd5, 3'd0, 3'd4, 3'd1, 1'b0);
    chk("m1_c1_valid", rsp_valid, 0);
    chk("m1_c1_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    chk("m1_c3_valid", rsp_valid, 0);
    chk("m1_c3_board", board_pos, exp_board);
    @(negedge clk);
    exp_board[4][1] = 3'b001; exp_board[5][0] = 3'b000;
    chk("m1_c4_valid", rsp_valid, 1);
    chk("m1_c4_ok", rsp_ok, 1);
    chk("m1_c4_err", rsp_err, 0);
    chk("m1_b41", board_pos[4][1], 3'b001);
    chk("m1_b50", board_pos[5][0], 3'b000);
    chk("m1_board", board_pos, exp_board);
    chk("m1_count", move_count, 1);
    finish_resp();

    // Move (5,2)->(4,3) held off by active video for 20 cycles
    frame_blank = 1'b0;
    send(1'b0, 3'd5, 3'd2, 3'd4, 3'd3, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      chk("m2_wait_board", board_pos, exp_board);
      chk("m2_wait_valid", rsp_valid, 0);
      if (i < 20) @(negedge clk);
    end
    frame_blank = 1'b1;
    @(negedge clk);
    chk("m2_c21_board", board_pos, exp_board);
    chk("m2_c21_valid", rsp_valid, 0);
    @(negedge clk);
    exp_board[4][3] = 3'b001; exp_board[5][2] = 3'b000;
    chk("m2_c22_board", board_pos, exp_board);
    chk("m2_c22_valid", rsp_valid, 1);
    chk("m2_c22_ok", rsp_ok, 1);
    chk("m2_count", move_count, 2);
    finish_resp();

    // Source empty
    send(1'b0, 3'd3, 3'd0, 3'd4, 3'd5, 1'b0);
    chk("e1_c1_valid", rsp_valid, 0);
    @(negedge clk);
    chk("e1_c2_valid", rsp_valid, 1);
    chk("e1_ok", rsp_ok, 0);
    chk("e1_err", rsp_err, 2'b01);
    finish_resp();

    // Destination occupied
    send(1'b0, 3'd0, 3'd1, 3'd1, 3'd0, 1'b0);
    @(negedge clk);
    chk("e2_c2_valid", rsp_valid, 1);
    chk("e2_ok", rsp_ok, 0);
    chk("e2_err", rsp_err, 2'b10);
    finish_resp();

    // Same square outranks the other checks
    send(1'b0, 3'd2, 3'd1, 3'd2, 3'd1, 1'b0);
    @(negedge clk);
    chk("e3_c2_valid", rsp_valid, 1);
    chk("e3_ok", rsp_ok, 0);
    chk("e3_err", rsp_err, 2'b11);
    finish_resp();
    chk("err_board", board_pos, exp_board);
    chk("err_count", move_count, 2);

    // Promote (2,1)->(3,0) with response back-pressure
    send(1'b0, 3'd2, 3'd1, 3'd3, 3'd0, 1'b1);
    repeat (3) @(negedge clk);
    exp_board[3][0] = 3'b111; exp_board[2][1] = 3'b000;
    chk("p_b30", board_pos[3][0], 3'b111);
    chk("p_board", board_pos, exp_board);
    chk("p_count", move_count, 3);
    req_valid = 1'b1; req_init = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("p_hold_valid", rsp_valid, 1);
      chk("p_hold_ok", rsp_ok, 1);
      chk("p_hold_err", rsp_err, 0);
      chk("p_hold_ready", req_ready, 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    finish_resp();
    chk("p_board_after", board_pos, exp_board);

    // Init restores the start layout and clears the counter
    send(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    exp_board = start_b;
    chk("i_valid", rsp_valid, 1);
    chk("i_ok", rsp_ok, 1);
    chk("i_err", rsp_err, 0);
    chk("i_board", board_pos, exp_board);
    chk("i_count", move_count, 0);
    finish_resp();

    // Reset while waiting for blanking aborts the move
    frame_blank = 1'b0;
    send(1'b0, 3'd5, 3'd4, 3'd4, 3'd5, 1'b0);
    @(negedge clk);
    chk("r_state_wait", dbg_state, 3'd2);
    reset = 1'b1; frame_blank = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("r_state_idle", dbg_state, 0);
    chk("r_req_ready", req_ready, 1);
    chk("r_rsp_valid", rsp_valid, 0);
    repeat (4) @(negedge clk);
    chk("r_rsp_valid_later", rsp_valid, 0);
    chk("r_board", board_pos, start_b);
    chk("r_count", move_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
